// File: rtl/transmitter_if.sv
// Host write-path bundle for the serial transmitter: the write strobe, the
// byte to queue and the buffer-ready flag returned to the host.
interface transmitter_if #(
    parameter int DATA_BITS = 8
) ();
    logic                 transmit_load;
    logic [DATA_BITS-1:0] transmit_data;
    logic                 TBR;

    // Host side: issues writes, watches the ready flag.
    modport master (
        output transmit_load,
        output transmit_data,
        input  TBR
    );

    // Transmitter side: accepts writes, reports whether the holding register is free.
    modport slave (
        input  transmit_load,
        input  transmit_data,
        output TBR
    );
endinterface

// File: rtl/transmitter.sv
// UART-style serial transmitter. One frame is a low start bit, DATA_BITS data
// bits LSB first and STOP_BITS high stop periods. Every bit boundary is a
// single-cycle baud_rate_generator pulse. A holding register lets the host
// queue the next byte while the shift register drives the line, so frames can
// run back to back without an idle bit. All outputs come straight from flops.
module transmitter #(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          baud_rate_generator,
    transmitter_if.slave  host,
    output logic          TxD,
    output logic          tx_busy
);

    localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_e;

    state_e               state_q,    state_d;
    logic [DATA_BITS-1:0] hold_q,     hold_d;
    logic [DATA_BITS-1:0] shift_q,    shift_d;
    logic [CNT_W-1:0]     bit_cnt_q,  bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 tbr_q,      tbr_d;
    logic                 txd_q,      txd_d;
    logic                 busy_q,     busy_d;

    logic                 transfer_s;
    logic [DATA_BITS-1:0] shifted_s;

    // The shift register contents after one right shift; its bit 0 is the next data bit.
    assign shifted_s = {1'b0, shift_q[DATA_BITS-1:1]};

    assign host.TBR = tbr_q;
    assign TxD      = txd_q;
    assign tx_busy  = busy_q;

    // State register and all datapath flops; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            hold_q     <= {DATA_BITS{1'b0}};
            shift_q    <= {DATA_BITS{1'b0}};
            bit_cnt_q  <= {CNT_W{1'b0}};
            stop_cnt_q <= 1'b0;
            tbr_q      <= 1'b1;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            tbr_q      <= tbr_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state logic: host writes into the holding register, and the
    // tick-driven frame sequencer that decides the next line level.
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        tbr_d      = tbr_q;
        txd_d      = txd_q;
        busy_d     = busy_q;
        transfer_s = 1'b0;

        // A write is only taken while the holding register is empty; writes
        // while it is full are silently dropped.
        if (host.transmit_load && tbr_q) begin
            hold_d = host.transmit_data;
            tbr_d  = 1'b0;
        end else begin
            hold_d = hold_q;
        end

        if (baud_rate_generator) begin
            case (state_q)
                ST_IDLE: begin
                    if (!tbr_q) begin
                        transfer_s = 1'b1;
                        state_d    = ST_START;
                        txd_d      = 1'b0;
                        busy_d     = 1'b1;
                    end else begin
                        state_d    = ST_IDLE;
                        txd_d      = 1'b1;
                        busy_d     = 1'b0;
                    end
                end
                ST_START: begin
                    state_d   = ST_DATA;
                    bit_cnt_d = {CNT_W{1'b0}};
                    txd_d     = shift_q[0];
                end
                ST_DATA: begin
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d    = ST_STOP;
                        stop_cnt_d = 1'b0;
                        txd_d      = 1'b1;
                    end else begin
                        shift_d    = shifted_s;
                        bit_cnt_d  = bit_cnt_q + CNT_ONE;
                        txd_d      = shifted_s[0];
                    end
                end
                ST_STOP: begin
                    if (stop_cnt_q == STOP_LAST) begin
                        // A queued byte starts immediately, giving back-to-back frames.
                        if (!tbr_q) begin
                            transfer_s = 1'b1;
                            state_d    = ST_START;
                            txd_d      = 1'b0;
                            busy_d     = 1'b1;
                        end else begin
                            state_d    = ST_IDLE;
                            txd_d      = 1'b1;
                            busy_d     = 1'b0;
                        end
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                        txd_d      = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    txd_d   = 1'b1;
                    busy_d  = 1'b0;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        // Moving the queued byte into the shift register frees the holding
        // register; a transfer only happens while it is full, so it never
        // coincides with an accepted write.
        if (transfer_s) begin
            shift_d = hold_q;
            tbr_d   = 1'b1;
        end else begin
            shift_d = shift_d;
        end
    end

endmodule

// File: tb/tb_transmitter.sv
// Directed bench for the serial transmitter: reset/idle, single frame,
// back-to-back frames, overrun, reset mid-frame and a loopback decode of
// random bytes. Ticks arrive every 16 clocks.
module tb_transmitter;

    logic       clk = 1'b0;
    logic       reset;
    logic       baud;
    logic       TxD;
    logic       tx_busy;
    int         vectors     = 0;
    int         miscompares = 0;
    int         tick_cnt    = 0;
    logic [7:0] lb_bytes [22];

    transmitter_if #(.DATA_BITS(8)) tx_if ();

    transmitter #(.DATA_BITS(8), .STOP_BITS(1)) dut (
        .clk                 (clk),
        .reset               (reset),
        .baud_rate_generator (baud),
        .host                (tx_if),
        .TxD                 (TxD),
        .tx_busy             (tx_busy)
    );

    always #5 clk = ~clk;

    // Tick source: one-clock pulse every 16 clocks, changed just after the edge.
    initial begin
        baud = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tick_cnt = (tick_cnt == 15) ? 0 : tick_cnt + 1;
            baud     = (tick_cnt == 15);
        end
    end

    // Hard time limit so the run can never hang.
    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next tick edge; TxD must not move in between.
    task automatic next_tick();
        logic ref_v;
        logic held;
        logic got;
        int   n;
        ref_v = TxD;
        held  = 1'b1;
        got   = 1'b0;
        n     = 0;
        while (!got && n < 64) begin
            @(posedge clk);
            n++;
            if (baud) begin
                got = 1'b1;
            end else begin
                #1;
                if (TxD !== ref_v) held = 1'b0;
            end
        end
        if (got) #1;
        check1("tick_seen", got, 1'b1);
        check1("txd_hold_between_ticks", held, 1'b1);
    endtask

    task automatic load_byte(input logic [7:0] d);
        tx_if.transmit_load = 1'b1;
        tx_if.transmit_data = d;
        @(posedge clk);
        #1;
        tx_if.transmit_load = 1'b0;
    endtask

    // Check one whole frame from its start tick; optionally queue the next byte
    // as soon as the holding register frees up.
    task automatic check_frame(input string name, input logic [0:9] exp,
                               input logic do_next, input logic [7:0] next_byte);
        for (int i = 0; i < 10; i++) begin
            next_tick();
            check1($sformatf("%s_bit%0d", name, i), TxD, exp[i]);
            check1($sformatf("%s_busy%0d", name, i), tx_busy, 1'b1);
            if (i == 0) begin
                check1($sformatf("%s_tbr_after_transfer", name), tx_if.TBR, 1'b1);
                if (do_next) begin
                    load_byte(next_byte);
                    check1($sformatf("%s_tbr_after_queue", name), tx_if.TBR, 1'b0);
                end
            end
        end
    endtask

    task automatic check_idle_end(input string name);
        next_tick();
        check1($sformatf("%s_end_txd", name), TxD, 1'b1);
        check1($sformatf("%s_end_busy", name), tx_busy, 1'b0);
        check1($sformatf("%s_end_tbr", name), tx_if.TBR, 1'b1);
    endtask

    initial begin
        logic       found;
        logic [7:0] rx;

        reset               = 1'b1;
        tx_if.transmit_load = 1'b0;
        tx_if.transmit_data = 8'h00;

        // Reset then idle.
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check1("reset_txd", TxD, 1'b1);
        check1("reset_tbr", tx_if.TBR, 1'b1);
        check1("reset_busy", tx_busy, 1'b0);
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            #1;
            check1("idle_txd", TxD, 1'b1);
            check1("idle_tbr", tx_if.TBR, 1'b1);
            check1("idle_busy", tx_busy, 1'b0);
        end

        // Single byte 8'hA5.
        next_tick();
        load_byte(8'hA5);
        check1("a5_tbr_after_load", tx_if.TBR, 1'b0);
        check1("a5_txd_before_tick", TxD, 1'b1);
        check1("a5_busy_before_tick", tx_busy, 1'b0);
        check_frame("a5", 10'b0101001011, 1'b0, 8'h00);
        check_idle_end("a5");

        // Back-to-back 8'h3C then 8'hC3 with no idle bit between frames.
        next_tick();
        load_byte(8'h3C);
        check_frame("b2b_3c", 10'b0001111001, 1'b1, 8'hC3);
        check_frame("b2b_c3", 10'b0110000111, 1'b0, 8'h00);
        check_idle_end("b2b");

        // Overrun: writes while the holding register is full are dropped.
        next_tick();
        load_byte(8'h55);
        load_byte(8'hFF);
        check1("ovr_tbr_after_ff", tx_if.TBR, 1'b0);
        load_byte(8'h00);
        check1("ovr_tbr_after_00", tx_if.TBR, 1'b0);
        check_frame("ovr_55", 10'b0101010101, 1'b0, 8'h00);
        check_idle_end("ovr");
        for (int t = 0; t < 3; t++) begin
            next_tick();
            check1("ovr_no_extra_txd", TxD, 1'b1);
            check1("ovr_no_extra_busy", tx_busy, 1'b0);
        end

        // Reset during the third data bit of 8'h0F with 8'hF0 queued.
        next_tick();
        load_byte(8'h0F);
        check1("rst_tbr_after_load", tx_if.TBR, 1'b0);
        next_tick();
        check1("rst_start_bit", TxD, 1'b0);
        load_byte(8'hF0);
        check1("rst_tbr_queued", tx_if.TBR, 1'b0);
        for (int b = 0; b < 3; b++) begin
            next_tick();
            check1("rst_data_bit", TxD, 1'b1);
        end
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check1("rst_mid_txd", TxD, 1'b1);
        check1("rst_mid_tbr", tx_if.TBR, 1'b1);
        check1("rst_mid_busy", tx_busy, 1'b0);
        reset = 1'b0;
        for (int t = 0; t < 3; t++) begin
            next_tick();
            check1("rst_after_txd", TxD, 1'b1);
            check1("rst_after_busy", tx_busy, 1'b0);
        end
        load_byte(8'h81);
        check_frame("rst_81", 10'b0100000011, 1'b0, 8'h00);
        check_idle_end("rst_81");

        // Loopback: decode the line by sampling at each tick, frames back to back.
        foreach (lb_bytes[i]) lb_bytes[i] = 8'($urandom_range(0, 255));
        next_tick();
        load_byte(lb_bytes[0]);
        for (int i = 0; i < 22; i++) begin
            found = 1'b0;
            for (int t = 0; t < 4 && !found; t++) begin
                next_tick();
                if (TxD === 1'b0) found = 1'b1;
            end
            check1("lb_start_found", found, 1'b1);
            if (i < 21) load_byte(lb_bytes[i+1]);
            rx = 8'h00;
            for (int k = 0; k < 8; k++) begin
                next_tick();
                rx[k] = TxD;
            end
            next_tick();
            check1("lb_stop_bit", TxD, 1'b1);
            check8($sformatf("lb_byte%0d", i), rx, lb_bytes[i]);
        end
        check_idle_end("lb");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
